// File: rtl/rtio_fifo_wr_arbiter.sv
// Round-robin arbiter feeding the RTIO event FIFO write port from NUM_REQ clkx8 producers.
// The winner's event is tagged with its index and held in a one-entry output stage.
module rtio_fifo_wr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int TAG_WIDTH     = 4,
    parameter int LOCK_MAX      = 16
) (
    input  logic                               clkx8,
    input  logic                               wrst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               fifo_full,
    output logic                               fifo_wr_en,
    output logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] fifo_din,
    output logic [31:0]                        accept_count,
    output logic [31:0]                        stall_count,
    output logic                               busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WORD_W = TAG_WIDTH + PAYLOAD_WIDTH;
    localparam int LCNT_W = $clog2(LOCK_MAX) + 1;

    logic                 out_valid;
    logic [WORD_W-1:0]    out_word;
    logic [IDX_W-1:0]     rr_ptr;
    logic [LCNT_W-1:0]    lock_cnt;
    logic [31:0]          accept_cnt;
    logic [31:0]          stall_cnt;

    logic                 slot_free;
    logic                 grant_any;
    logic                 grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic [TAG_WIDTH-1:0] grant_tag;
    logic [PAYLOAD_WIDTH-1:0] grant_data;
    int                   cand;

    // Handshake: an event moves when req_valid[i] & req_ready[i] at a clkx8 edge;
    // a word leaves the stage when fifo_wr_en is high. The stage reloads in the same
    // cycle it drains, so the FIFO sees one event per clock while not full.
    assign slot_free  = ~out_valid | ~fifo_full;
    assign fifo_wr_en = out_valid & ~fifo_full & ~wrst;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && req_valid[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!wrst && slot_free && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant      = |req_ready;
    assign grant_tag  = TAG_WIDTH'(grant_idx);
    assign grant_data = req_data[int'(grant_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign next_ptr   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clkx8) begin
        if (wrst) begin
            out_valid  <= 1'b0;
            out_word   <= '0;
            rr_ptr     <= '0;
            lock_cnt   <= '0;
            accept_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_word  <= {grant_tag, grant_data};
            end else if (fifo_wr_en) begin
                out_valid <= 1'b0;
            end

            // A locked winner keeps the pointer until it has had LOCK_MAX grants in a row.
            if (grant) begin
                if (req_lock[grant_idx] && (lock_cnt < LCNT_W'(LOCK_MAX - 1))) begin
                    rr_ptr   <= grant_idx;
                    lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    rr_ptr   <= next_ptr;
                    lock_cnt <= '0;
                end
            end

            if (fifo_wr_en) begin
                accept_cnt <= accept_cnt + 32'd1;
            end
            if (out_valid && fifo_full && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign fifo_din     = out_word;
    assign accept_count = accept_cnt;
    assign stall_count  = stall_cnt;
    assign busy         = out_valid;

endmodule

// File: tb/tb_rtio_fifo_wr_arbiter.sv
// Bench for rtio_fifo_wr_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_rtio_fifo_wr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int PW       = 64;
    localparam int TW       = 4;
    localparam int LOCK_MAX = 16;
    localparam int WORD_W   = TW + PW;

    logic                    clkx8 = 1'b0;
    logic                    wrst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_lock;
    logic [NUM_REQ*PW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [WORD_W-1:0]       fifo_din;
    logic [31:0]             accept_count;
    logic [31:0]             stall_count;
    logic                    busy;

    always #5 clkx8 = ~clkx8;

    rtio_fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_WIDTH(PW), .TAG_WIDTH(TW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clkx8(clkx8), .wrst(wrst), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .accept_count(accept_count),
        .stall_count(stall_count), .busy(busy)
    );

    // reference model state
    logic              m_known = 1'b0;
    logic              m_ov;
    logic [WORD_W-1:0] m_word;
    int                m_ptr;
    int                m_run;
    int                m_last_g = -1;
    logic [31:0]       m_acc;
    logic [31:0]       m_stall;
    logic [WORD_W-1:0] exp_q[$];
    int                wr_tags[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; checks, steps the model
    // across the next posedge and returns at the following negedge.
    task automatic cycle();
        int                 g;
        logic [NUM_REQ-1:0] e_ready;
        logic               e_wr;
        logic [WORD_W-1:0]  front;
        #1;
        g = -1;
        if (!wrst && (!m_ov || !fifo_full)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_wr = !wrst && m_ov && !fifo_full;
        chk("req_ready", WORD_W'(req_ready), WORD_W'(e_ready));
        chk("fifo_wr_en", WORD_W'(fifo_wr_en), WORD_W'(e_wr));
        if (m_known) begin
            chk("busy", WORD_W'(busy), WORD_W'(m_ov));
            chk("fifo_din", fifo_din, m_word);
            chk("accept_count", WORD_W'(accept_count), WORD_W'(m_acc));
            chk("stall_count", WORD_W'(stall_count), WORD_W'(m_stall));
            if (fifo_wr_en === 1'b1) begin
                wr_tags.push_back(int'(fifo_din[WORD_W-1 -: TW]));
                if (exp_q.size() > 0) begin
                    front = exp_q.pop_front();
                    chk("sb_word", fifo_din, front);
                end else begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL sb_underflow: observed write of %0h expected no write", fifo_din);
                end
            end
        end
        m_last_g = g;
        if (wrst) begin
            m_ov = 1'b0; m_word = '0; m_ptr = 0; m_run = 0;
            m_acc = '0; m_stall = '0; m_known = 1'b1;
            exp_q.delete();
        end else begin
            if (e_wr) m_acc = m_acc + 32'd1;
            if (m_ov && fifo_full && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (g >= 0) begin
                m_word = {TW'(g), req_data[g*PW +: PW]};
                exp_q.push_back(m_word);
                m_ov = 1'b1;
                if (req_lock[g] && m_run < LOCK_MAX - 1) begin
                    m_ptr = g;
                    m_run = m_run + 1;
                end else begin
                    m_ptr = (g + 1) % NUM_REQ;
                    m_run = 0;
                end
            end else if (e_wr) begin
                m_ov = 1'b0;
            end
        end
        @(negedge clkx8);
    endtask

    initial begin
        logic [PW-1:0] d0;
        wrst = 1'b1; req_valid = '1; req_lock = '0; fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*PW +: PW] = {$urandom, $urandom};
        @(negedge clkx8);

        // reset held with every requester asking
        repeat (3) cycle();
        wrst = 1'b0;
        #1;
        chk("rst_first_grant", WORD_W'(req_ready), WORD_W'(4'b0001));
        chk("rst_accept", WORD_W'(accept_count), '0);
        chk("rst_stall", WORD_W'(stall_count), '0);

        // fairness: all valid, FIFO never full
        wr_tags.delete();
        repeat (12) cycle();
        req_valid = '0;
        repeat (2) cycle();
        chk("fair_count", WORD_W'(wr_tags.size()), WORD_W'(12));
        for (int i = 0; i < wr_tags.size() && i < 12; i++)
            chk("fair_tag", WORD_W'(wr_tags[i]), WORD_W'(i % 4));
        chk("fair_accept", WORD_W'(accept_count), WORD_W'(12));

        // backpressure on a single held word
        wrst = 1'b1; cycle(); wrst = 1'b0;
        d0 = {$urandom, $urandom};
        req_data[0 +: PW] = d0;
        req_valid = 4'b0001;
        cycle();
        req_valid = '1; fifo_full = 1'b1;
        repeat (5) cycle();
        chk("bp_stall", WORD_W'(stall_count), WORD_W'(5));
        chk("bp_din", fifo_din, {4'h0, d0});
        chk("bp_wr_en", WORD_W'(fifo_wr_en), '0);
        fifo_full = 1'b0;
        #1;
        chk("bp_release_wr", WORD_W'(fifo_wr_en), WORD_W'(1));
        chk("bp_regrant", WORD_W'(req_ready), WORD_W'(4'b0010));
        cycle();
        req_valid = '0;
        repeat (2) cycle();

        // lock bound: req1 locked against req2
        wrst = 1'b1; cycle(); wrst = 1'b0;
        wr_tags.delete();
        req_valid = 4'b0110; req_lock = 4'b0010;
        repeat (19) cycle();
        req_valid = '0; req_lock = '0;
        repeat (2) cycle();
        chk("lock_count", WORD_W'(wr_tags.size()), WORD_W'(19));
        for (int i = 0; i < wr_tags.size() && i < 19; i++)
            chk("lock_tag", WORD_W'(wr_tags[i]), WORD_W'((i == 16) ? 2 : 1));

        // sparse traffic and pointer wrap
        req_data[3*PW +: PW] = 64'hDEADBEEF_00000001;
        req_valid = 4'b1000;
        cycle();
        chk("sparse_din", fifo_din, 68'h3_DEADBEEF_00000001);
        req_valid = 4'b0001;
        cycle();
        chk("wrap_tag", WORD_W'(fifo_din[WORD_W-1 -: TW]), '0);
        req_valid = '0;
        repeat (2) cycle();

        // random traffic with occasional resets and held locks
        for (int n = 0; n < 400; n++) begin
            wrst = ($urandom_range(0, 99) == 0);
            fifo_full = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_valid[i] && m_last_g != i && $urandom_range(0, 9) != 0)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[i*PW +: PW] = {$urandom, $urandom};
                end
                req_lock[i] = (i == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            end
            cycle();
        end

        // counter saturation and wrap
        wrst = 1'b0; req_valid = '0; req_lock = '0; fifo_full = 1'b0;
        repeat (2) cycle();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        m_stall = 32'hFFFF_FFFE;
        req_valid = 4'b0001; fifo_full = 1'b1;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        chk("stall_saturate", WORD_W'(stall_count), WORD_W'(32'hFFFF_FFFF));
        force dut.accept_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.accept_cnt;
        m_acc = 32'hFFFF_FFFF;
        fifo_full = 1'b0;
        repeat (2) cycle();
        chk("accept_wrap", WORD_W'(accept_count), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        if (n_mis != 0) $error("%0d comparisons disagreed with the reference model", n_mis);
        $finish;
    end

endmodule

// File: doc/rtio_fifo_wr_arbiter.md
Name: rtio_fifo_wr_arbiter

Overview:
Round-robin arbiter sharing the single write port of the RTIO dual-clock event FIFO among NUM_REQ event producers in the clkx8 domain. Each producer offers a PAYLOAD_WIDTH event through a valid/ready handshake. The winner's event is tagged with its requester index and registered into a one-entry output stage that drives the FIFO write side. The stage honours FIFO backpressure, supports locked bursts and keeps throughput/stall statistics.

Parameters:
NUM_REQ, 4, number of requesters; 2 <= NUM_REQ <= 2**TAG_WIDTH
PAYLOAD_WIDTH, 64, event payload width (timestamp + data)
TAG_WIDTH, 4, requester-index tag width; FIFO word = TAG_WIDTH + PAYLOAD_WIDTH (68 by default)
LOCK_MAX, 16, max consecutive grants to one locked requester before forced rotation
IDX_W, $clog2(NUM_REQ), derived, not overridable

Ports:
clkx8  in  1  write-side clock (800 MHz)
wrst  in  1  reset, synchronous, active-high, in clkx8 domain
req_valid  in  NUM_REQ  per-requester event valid
req_lock  in  NUM_REQ  per-requester burst lock; holds grant while set
req_data  in  NUM_REQ*PAYLOAD_WIDTH  packed payloads; requester i occupies bits [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
req_ready  out  NUM_REQ  one-hot (or zero) accept strobe
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_din  out  TAG_WIDTH+PAYLOAD_WIDTH  {tag, payload}, tag zero-extended requester index
accept_count  out  32  events written into FIFO, wraps modulo 2**32
stall_count  out  32  cycles with a pending word blocked by full, saturates at 0xFFFFFFFF
busy  out  1  output stage holds a word

Behaviour:
- Reset (wrst=1 at posedge clkx8): out_valid=0, fifo_din=0, rr_ptr=0, lock_cnt=0, accept_count=0, stall_count=0. While wrst=1: req_ready=0, fifo_wr_en=0. Reset mid-burst or mid-stall discards the held word. No partial write is issued.
- Write side: fifo_wr_en = out_valid & ~fifo_full (combinational). A word is consumed in the cycle fifo_wr_en=1. accept_count increments in that cycle. While out_valid & fifo_full, fifo_din and the tag stay stable and stall_count increments (saturating).
- Load slot: slot_free = ~out_valid | ~fifo_full. Back-to-back operation gives one event per clkx8 when the FIFO is not full.
- Arbitration (combinational, each cycle with slot_free=1): g = first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ. If any req_valid is set, req_ready[g]=1 and all others are 0. If no request, or slot_free=0, req_ready=0.
- On a grant, next cycle: out_valid=1, fifo_din={g, req_data[g]}. If no grant and the word was consumed, out_valid=0.
- Pointer update on grant g:
  - If req_lock[g]=1 and lock_cnt < LOCK_MAX-1: rr_ptr=g and lock_cnt increments.
  - Otherwise: rr_ptr=(g+1) mod NUM_REQ and lock_cnt=0.
  - No grant: rr_ptr and lock_cnt hold.
- Lock bound: a locked requester receives at most LOCK_MAX consecutive grants. It is then forced past, even if req_lock stays high.
- Requester rule: req_data[i] must be stable while req_valid[i]=1 and req_ready[i]=0. Deasserting req_valid without a handshake is permitted; the arbiter does not latch it.
- Latency: req handshake to fifo_wr_en = 1 cycle when not full.
- Simultaneous consume and load in one cycle is required; no bubble.
- busy = out_valid.

Test Plan:
- Reset: wrst held 3 cycles with all req_valid=1 -> req_ready=0, fifo_wr_en=0, counters 0. First grant after release goes to req 0.
- Fairness: all 4 requesters always valid, fifo_full=0, 12 cycles -> fifo_din tags 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; accept_count=12.
- Backpressure: single word pending, fifo_full=1 for 5 cycles -> fifo_din stable, fifo_wr_en=0, req_ready all 0, stall_count=5. Word written the cycle full drops; a new grant is taken in that same cycle.
- Lock bound: req 1 valid with lock=1, req 2 valid, LOCK_MAX=16 -> 16 tag-1 words, then a tag-2 word, then req 1 resumes.
- Sparse/wrap: only req 3 then only req 0 valid, data 0xDEADBEEF_00000001 -> fifo_din=0x3DEADBEEF00000001, then tag 0 word; rr_ptr wraps 3->0.
- Saturation: force stall_count to 0xFFFFFFFE and stall 3 cycles -> stall_count=0xFFFFFFFF. accept_count at 0xFFFFFFFF plus one write -> 0.
